// File: rtl/fifo_thresh_if.sv
// Handshake/data bundle between a producer/consumer pair and fifo_thresh.
interface fifo_thresh_if #(
  parameter int DWIDTH     = 16,
  parameter int LOG2_DEPTH = 4
);
  logic [DWIDTH-1:0]   din;
  logic                push;
  logic                full;
  logic [DWIDTH-1:0]   dout;
  logic                pop;
  logic                empty;
  logic [LOG2_DEPTH:0] count;
  logic                almost_full;
  logic                almost_empty;
  logic                flush;
  logic                overflow;
  logic                underflow;
  logic                clr_err;

  // FIFO side
  modport slave (
    input  din, push, pop, flush, clr_err,
    output dout, full, empty, count, almost_full, almost_empty, overflow, underflow
  );

  // producer/consumer side
  modport master (
    output din, push, pop, flush, clr_err,
    input  dout, full, empty, count, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_thresh.sv
// Show-ahead synchronous FIFO with occupancy count, almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module fifo_thresh #(
  parameter int DWIDTH     = 16,
  parameter int LOG2_DEPTH = 4,
  parameter int AF_LEVEL   = (1 << LOG2_DEPTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic         clk,
  input logic         reset,
  fifo_thresh_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_C = DEPTH[LOG2_DEPTH:0];
  localparam logic [LOG2_DEPTH:0] AF_C    = AF_LEVEL[LOG2_DEPTH:0];
  localparam logic [LOG2_DEPTH:0] AE_C    = AE_LEVEL[LOG2_DEPTH:0];

  // Threshold ordering must be sane or the flags become meaningless.
  if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
    $error("fifo_thresh: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [DWIDTH-1:0]     ram [DEPTH];
  logic [LOG2_DEPTH-1:0] wptr, rptr;
  logic [LOG2_DEPTH:0]   count, count_nxt;
  logic                  full, empty, af, ae, ovf, udf;
  logic                  wr, rd;

  // Acceptance: a push at full rides on a same-cycle pop; a pop at empty is never taken.
  always_comb begin
    wr        = bus.push && (!full || bus.pop);
    rd        = bus.pop && !empty;
    count_nxt = count;
    if (wr && !rd)      count_nxt = count + 1'b1;
    else if (rd && !wr) count_nxt = count - 1'b1;
  end

  // Storage write; contents are never reset, only pointers are.
  always_ff @(posedge clk) begin
    if (!reset && !bus.flush && wr) ram[wptr] <= bus.din;
  end

  // Pointers, count, registered flags (from next count) and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      af    <= 1'b0;
      ae    <= 1'b1;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (bus.flush) begin
      // discard everything; error flags keep their value
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      af    <= (AF_LEVEL == 0);
      ae    <= 1'b1;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      af    <= (count_nxt >= AF_C);
      ae    <= (count_nxt <= AE_C);
      // an error event wins over a coincident clear
      ovf   <= (bus.push && full && !bus.pop) || (ovf && !bus.clr_err);
      udf   <= (bus.pop && empty) || (udf && !bus.clr_err);
    end
  end

  assign bus.dout         = ram[rptr];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.almost_full  = af;
  assign bus.almost_empty = ae;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
endmodule
